external_pin_bank: RTL and testbench

EXTERNAL_PIN_BANK -- requirements
Module: external_pin_bank

---
 rtl/external_pin_pkg.sv | 25 ++
 rtl/pin_debounce.sv | 53 +++++
 rtl/external_pin_bank.sv | 116 +++++++++++
 tb/tb_external_pin_bank.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/external_pin_pkg.sv
// Shared register map, default sizing and reset values for the external pin bank.
package external_pin_pkg;

  localparam int unsigned DefDebounceBits = 4;

  typedef enum logic [2:0] {
    RegOut      = 3'd0,
    RegOe       = 3'd1,
    RegIn       = 3'd2,
    RegRiseEn   = 3'd3,
    RegFallEn   = 3'd4,
    RegPending  = 3'd5,
    RegDebounce = 3'd6,
    RegReserved = 3'd7
  } reg_addr_e;

  // Wide enough for any WIDTH up to 64; users slice to the bank width.
  localparam logic [63:0] RstOut      = '0;
  localparam logic [63:0] RstOe       = '0;
  localparam logic [63:0] RstRiseEn   = '0;
  localparam logic [63:0] RstFallEn   = '0;
  localparam logic [63:0] RstPending  = '0;
  localparam logic [63:0] RstDebounce = '0;

endpackage

// File: rtl/pin_debounce.sv
// One pin channel: multi-flop synchronizer followed by a counter-based debounce filter.
module pin_debounce #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEBOUNCE_BITS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_pin,
  input  logic [DEBOUNCE_BITS-1:0] i_thresh,
  output logic                     o_filt
);

  logic [SYNC_STAGES-1:0]   r_sync;
  logic [DEBOUNCE_BITS-1:0] r_cnt;
  logic [DEBOUNCE_BITS-1:0] w_cnt_d;
  logic                     r_filt;
  logic                     w_filt_d;
  logic                     w_synced;
  logic [DEBOUNCE_BITS:0]   w_cnt_inc;
  logic [DEBOUNCE_BITS:0]   w_thresh_eff;

  always_comb begin
    w_synced     = r_sync[SYNC_STAGES-1];
    w_cnt_inc    = {1'b0, r_cnt} + (DEBOUNCE_BITS+1)'(1);
    // A zero threshold behaves like one so the filter never stalls.
    w_thresh_eff = (i_thresh == '0) ? (DEBOUNCE_BITS+1)'(1) : {1'b0, i_thresh};
    w_cnt_d      = r_cnt;
    w_filt_d     = r_filt;
    if (w_synced == r_filt) begin
      w_cnt_d = '0;
    end else if (w_cnt_inc >= w_thresh_eff) begin
      w_filt_d = w_synced;
      w_cnt_d  = '0;
    end else begin
      w_cnt_d = w_cnt_inc[DEBOUNCE_BITS-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_cnt  <= w_cnt_d;
      r_filt <= w_filt_d;
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/external_pin_bank.sv
// Bank of debounced GPIO-style pins with a small register interface and
// edge-triggered sticky interrupt flags.
module external_pin_bank
  import external_pin_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEBOUNCE_BITS = DefDebounceBits
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [2:0]       req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             irq
);

  logic [WIDTH-1:0]         r_out;
  logic [WIDTH-1:0]         r_oe;
  logic [WIDTH-1:0]         r_rise_en;
  logic [WIDTH-1:0]         r_fall_en;
  logic [WIDTH-1:0]         r_pend;
  logic [WIDTH-1:0]         r_f_prev;
  logic [WIDTH-1:0]         r_rsp_data;
  logic [DEBOUNCE_BITS-1:0] r_debounce;
  logic                     r_rsp_valid;
  logic                     r_irq;

  logic [WIDTH-1:0]         w_filt;
  logic [WIDTH-1:0]         w_set;
  logic [WIDTH-1:0]         w_clr;
  logic [WIDTH-1:0]         w_rd_data;
  logic                     w_wr;
  logic                     w_rd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pin_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_pin_debounce (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_pin   (pin_in[i]),
      .i_thresh(r_debounce),
      .o_filt  (w_filt[i])
    );
  end

  always_comb begin
    w_wr  = req_valid & req_write;
    w_rd  = req_valid & ~req_write;
    // Edges are seen one cycle after the filtered bit moves, so a later enable
    // write cannot pick up an old transition.
    w_set = (w_filt & ~r_f_prev & r_rise_en) | (~w_filt & r_f_prev & r_fall_en);
    w_clr = (w_wr && (req_addr == RegPending)) ? req_data : '0;

    w_rd_data = '0;
    case (reg_addr_e'(req_addr))
      RegOut:      w_rd_data = r_out;
      RegOe:       w_rd_data = r_oe;
      RegIn:       w_rd_data = w_filt;
      RegRiseEn:   w_rd_data = r_rise_en;
      RegFallEn:   w_rd_data = r_fall_en;
      RegPending:  w_rd_data = r_pend;
      RegDebounce: w_rd_data[DEBOUNCE_BITS-1:0] = r_debounce;
      default:     w_rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out       <= RstOut[WIDTH-1:0];
      r_oe        <= RstOe[WIDTH-1:0];
      r_rise_en   <= RstRiseEn[WIDTH-1:0];
      r_fall_en   <= RstFallEn[WIDTH-1:0];
      r_pend      <= RstPending[WIDTH-1:0];
      r_debounce  <= RstDebounce[DEBOUNCE_BITS-1:0];
      r_f_prev    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr) begin
        case (reg_addr_e'(req_addr))
          RegOut:      r_out      <= req_data;
          RegOe:       r_oe       <= req_data;
          RegRiseEn:   r_rise_en  <= req_data;
          RegFallEn:   r_fall_en  <= req_data;
          RegDebounce: r_debounce <= req_data[DEBOUNCE_BITS-1:0];
          default:     ;
        endcase
      end
      // New events win over a simultaneous write-1-to-clear.
      r_pend      <= (r_pend & ~w_clr) | w_set;
      r_f_prev    <= w_filt;
      r_irq       <= |r_pend;
      r_rsp_valid <= w_rd;
      if (w_rd) begin
        r_rsp_data <= w_rd_data;
      end
    end
  end

  assign pin_out   = r_out;
  assign pin_oe    = r_oe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign irq       = r_irq;

endmodule

// File: tb/tb_external_pin_bank.sv
// Directed self-checking bench for external_pin_bank with default parameters.
module tb_external_pin_bank;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pin_in;
  logic [31:0] pin_out;
  logic [31:0] pin_oe;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rdata;

  external_pin_bank dut (
    .CLK      (CLK),
    .RST      (RST),
    .pin_in   (pin_in),
    .pin_out  (pin_out),
    .pin_oe   (pin_oe),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .irq      (irq)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_data  = data;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] addr, output logic [31:0] data);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    data = rsp_data;
  endtask

  initial begin
    RST = 1'b1; pin_in = '0;
    // A read presented during reset must be dropped.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd0; req_data = '0;
    tick(2);
    check_eq("rst_pin_out", pin_out, 32'h0);
    check_eq("rst_pin_oe", pin_oe, 32'h0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    RST = 1'b0; req_valid = 1'b0;
    tick();
    check_eq("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Register write/readback
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'hA5);
    check_eq("pin_oe", pin_oe, 32'h0000_00FF);
    check_eq("pin_out", pin_out, 32'h0000_00A5);
    rd(3'd0, rdata); check_eq("rd_out", rdata, 32'hA5);
    rd(3'd1, rdata); check_eq("rd_oe_b2b", rdata, 32'hFF);
    tick();
    check_eq("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, rdata); check_eq("rd_reserved", rdata, 32'h0);
    wr(3'd6, 32'hFFFF_FFF3);
    rd(3'd6, rdata); check_eq("rd_debounce", rdata, 32'h3);
    req_write = 1'b1; req_addr = 3'd0; req_data = 32'h0; req_valid = 1'b0;
    tick();
    req_write = 1'b0;
    check_eq("ignore_no_valid", pin_out, 32'hA5);

    // Glitch of two cycles is filtered out
    wr(3'd3, 32'h1);
    pin_in = 32'h1; tick(2);
    pin_in = 32'h0; tick(8);
    rd(3'd2, rdata); check_eq("glitch_in", rdata, 32'h0);
    rd(3'd5, rdata); check_eq("glitch_pend", rdata, 32'h0);

    // Stable rise: IN after 5 cycles, PENDING at 6, irq at 7
    pin_in = 32'h1; tick(4);
    rd(3'd2, rdata); check_eq("rise_in_c4", rdata, 32'h0);
    check_eq("rise_irq_c5", {31'd0, irq}, 32'd0);
    rd(3'd2, rdata); check_eq("rise_in_c5", rdata, 32'h1);
    check_eq("rise_irq_c6", {31'd0, irq}, 32'd0);
    rd(3'd5, rdata); check_eq("rise_pend_c6", rdata, 32'h1);
    check_eq("rise_irq_c7", {31'd0, irq}, 32'd1);

    // Set-over-clear on a collision
    wr(3'd3, 32'h3);
    wr(3'd4, 32'h2);
    pin_in = 32'h3; tick(8);
    rd(3'd5, rdata); check_eq("pend_both", rdata, 32'h3);
    pin_in = 32'h1; tick(5);
    wr(3'd5, 32'h1);
    rd(3'd5, rdata); check_eq("w1c_collide_a", rdata, 32'h2);
    check_eq("irq_held", {31'd0, irq}, 32'd1);
    pin_in = 32'h3; tick(5);
    wr(3'd5, 32'h3);
    rd(3'd5, rdata); check_eq("w1c_collide_b", rdata, 32'h2);
    wr(3'd5, 32'h2);
    check_eq("irq_lag", {31'd0, irq}, 32'd1);
    tick();
    check_eq("irq_clear", {31'd0, irq}, 32'd0);
    rd(3'd5, rdata); check_eq("pend_cleared", rdata, 32'h0);

    // Enabling after the edge must not set PENDING
    wr(3'd3, 32'h0);
    pin_in = 32'hB; tick(8);
    wr(3'd3, 32'h8);
    tick(2);
    rd(3'd5, rdata); check_eq("late_enable", rdata, 32'h0);
    rd(3'd2, rdata); check_eq("in_b", rdata, 32'hB);

    // Fall detect with zero debounce: PENDING after SYNC_STAGES+2 cycles
    wr(3'd6, 32'h0);
    wr(3'd4, 32'h4);
    pin_in = 32'hF; tick(5);
    rd(3'd5, rdata); check_eq("fall_pre", rdata, 32'h0);
    pin_in = 32'hB; tick(3);
    rd(3'd5, rdata); check_eq("fall_c3", rdata, 32'h0);
    rd(3'd5, rdata); check_eq("fall_c4", rdata, 32'h4);

    // Reset in the middle of a debounce count
    wr(3'd0, 32'hFF);
    wr(3'd6, 32'h5);
    pin_in = 32'hA; tick(3);
    RST = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd0;
    tick();
    check_eq("mid_rst_out", pin_out, 32'h0);
    check_eq("mid_rst_oe", pin_oe, 32'h0);
    check_eq("mid_rst_irq", {31'd0, irq}, 32'd0);
    check_eq("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("mid_rst_rsp_data", rsp_data, 32'h0);
    RST = 1'b0; req_valid = 1'b0;
    tick(5);
    rd(3'd2, rdata); check_eq("post_rst_in", rdata, 32'hA);
    rd(3'd5, rdata); check_eq("post_rst_pend", rdata, 32'h0);
    check_eq("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
